board_renderer_vga: RTL

- Pixel-generation stage that sits directly downstream of the VGA synchronizer and upstream of the DAC outputs.
- Consumes the synchronizer's pixel coordinates and sync/blank strobes.
- Draws a 4x4 game board of coloured cells and re-times the sync signals so they stay aligned with the registered RGB.
- Board contents are written by game logic into a shadow copy and transferred atomically to the displayed copy at the start of vertical blanking, so frames never tear.

---
 rtl/board_renderer_vga.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/board_renderer_vga.sv
// Pixel stage behind the VGA synchronizer: draws a 4x4 board of coloured
// cells with a fixed two-cycle latency and re-times sync/blank to match.
// Board writes land in a shadow copy that is copied to the displayed copy
// at the start of vertical blanking, so a frame always shows one snapshot.
module board_renderer_vga #(
   parameter int HACTIVE = 640,
   parameter int VACTIVE = 480,
   parameter int GRID_X0 = 120,
   parameter int GRID_Y0 = 40,
   parameter int CELL    = 100,
   parameter int BORDER  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       sync_h_in,
   input  logic       sync_v_in,
   input  logic       blank_in,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [3:0] wr_cell,
   input  logic [3:0] wr_code,
   input  logic       commit,
   output logic       commit_ack,
   output logic       sync_h_out,
   output logic       sync_v_out,
   output logic       blank_out,
   output logic [7:0] Red,
   output logic [7:0] Green,
   output logic [7:0] Blue
);

   localparam logic [10:0] GX0    = 11'(GRID_X0);
   localparam logic [10:0] GX1    = 11'(GRID_X0 + CELL);
   localparam logic [10:0] GX2    = 11'(GRID_X0 + 2*CELL);
   localparam logic [10:0] GX3    = 11'(GRID_X0 + 3*CELL);
   localparam logic [10:0] GX_END = 11'(GRID_X0 + 4*CELL);
   localparam logic [10:0] GY0    = 11'(GRID_Y0);
   localparam logic [10:0] GY1    = 11'(GRID_Y0 + CELL);
   localparam logic [10:0] GY2    = 11'(GRID_Y0 + 2*CELL);
   localparam logic [10:0] GY3    = 11'(GRID_Y0 + 3*CELL);
   localparam logic [10:0] GY_END = 11'(GRID_Y0 + 4*CELL);
   localparam logic [10:0] BRD    = 11'(BORDER);
   localparam logic [10:0] HA     = 11'(HACTIVE);
   localparam logic [10:0] VA     = 11'(VACTIVE);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t      state;
   logic [3:0]  shadow [16];
   logic [3:0]  live   [16];

   logic [10:0] xe, ye, x_edge, y_edge, ox_c, oy_c;
   logic [1:0]  cx_c, cy_c;
   logic        in_grid_c, border_c, vblank_start;

   logic        s1_hs, s1_vs, s1_bl, s1_in, s1_border;
   logic [1:0]  s1_cx, s1_cy;
   logic [3:0]  cell_code;
   logic [23:0] rgb_c;

   assign xe = {1'b0, x};
   assign ye = {1'b0, y};
   assign vblank_start = (x == '0) && (ye == VA);

   // Cell classification by comparing against the constant cell edges
   always_comb begin
      cx_c   = 2'd0;
      x_edge = GX0;
      if (xe >= GX3)      begin cx_c = 2'd3; x_edge = GX3; end
      else if (xe >= GX2) begin cx_c = 2'd2; x_edge = GX2; end
      else if (xe >= GX1) begin cx_c = 2'd1; x_edge = GX1; end
      cy_c   = 2'd0;
      y_edge = GY0;
      if (ye >= GY3)      begin cy_c = 2'd3; y_edge = GY3; end
      else if (ye >= GY2) begin cy_c = 2'd2; y_edge = GY2; end
      else if (ye >= GY1) begin cy_c = 2'd1; y_edge = GY1; end
      ox_c      = xe - x_edge;
      oy_c      = ye - y_edge;
      in_grid_c = (xe >= GX0) && (xe < GX_END) && (ye >= GY0) && (ye < GY_END)
                  && (xe < HA) && (ye < VA);
      border_c  = (in_grid_c && ((ox_c < BRD) || (oy_c < BRD)))
                  || (xe == GX_END - 11'd1) || (ye == GY_END - 11'd1);
   end

   // Stage 1: register strobes and pixel classification
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         s1_bl     <= 1'b0;
         s1_in     <= 1'b0;
         s1_border <= 1'b0;
         s1_cx     <= '0;
         s1_cy     <= '0;
      end else begin
         s1_hs     <= sync_h_in;
         s1_vs     <= sync_v_in;
         s1_bl     <= blank_in;
         s1_in     <= in_grid_c;
         s1_border <= border_c;
         s1_cx     <= cx_c;
         s1_cy     <= cy_c;
      end
   end

   // Colour rules in priority order using the displayed board
   always_comb begin
      cell_code = live[{s1_cy, s1_cx}];
      rgb_c     = '0;
      if (!s1_bl || !s1_in)    rgb_c = '0;
      else if (s1_border)      rgb_c = 24'h404040;
      else if (cell_code == 0) rgb_c = 24'h202020;
      else rgb_c = {cell_code, 4'h0, 8'hFF - {cell_code, 4'h0}, 8'h80};
   end

   // Stage 2: register colour and the re-timed strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_h_out <= 1'b1;
         sync_v_out <= 1'b1;
         blank_out  <= 1'b0;
         Red        <= '0;
         Green      <= '0;
         Blue       <= '0;
      end else begin
         sync_h_out <= s1_hs;
         sync_v_out <= s1_vs;
         blank_out  <= s1_bl;
         {Red, Green, Blue} <= rgb_c;
      end
   end

   // Write port, commit FSM and shadow-to-live transfer at vblank start
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ready   <= 1'b1;
         commit_ack <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) begin
            shadow[i] <= '0;
            live[i]   <= '0;
         end
      end else begin
         commit_ack <= 1'b0;
         if (wr_valid && wr_ready) shadow[wr_cell] <= wr_code;
         case (state)
            IDLE: begin
               if (commit) begin
                  state    <= PENDING;
                  wr_ready <= 1'b0;
               end
            end
            PENDING: begin
               if (vblank_start) begin
                  for (int unsigned i = 0; i < 16; i++) live[i] <= shadow[i];
                  commit_ack <= 1'b1;
                  wr_ready   <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
